// File: rtl/wisc_pkg.sv
// Shared ISA constants and fetch-side types for the WISC front end.
package wisc_pkg;
  localparam int unsigned PC_W     = 16;
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 11;
  localparam logic [4:0]  OP_HALT  = 5'b00000;
  localparam logic [4:0]  OP_NOP   = 5'b00001;
  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DROP
  } fetch_state_t;
endpackage

// File: rtl/fq_storage.sv
// Circular buffer holding {instruction, pc} entries for the fetch queue.
module fq_storage
  import wisc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == DEPTH_V);
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with queue, redirect and HALT handling.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_W     = wisc_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [15:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc,
  output logic [PC_W-1:0] dec_pc_inc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);
  import wisc_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH);
  localparam int unsigned EW = 16 + PC_W;
  localparam logic [CW:0] DEPTH_V = DEPTH[CW:0];

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d;
  logic            halt_pend_q, halt_pend_d, halted_q, halted_d;
  logic [CW:0]     count, occ;
  logic            full, empty, push, pop, redir, outstanding, accept, halt_in, bypass, consume;
  logic [EW-1:0]   rd_data, wr_data;
  logic [15:0]     head_instr;
  logic [PC_W-1:0] head_pc;

  fq_storage #(.DEPTH(DEPTH), .W(EW)) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (redir),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    redir       = redirect && !halted_q;
    outstanding = (state_q != FS_IDLE);
    accept      = (state_q == FS_WAIT) && imem_valid && !redir;
    halt_in     = accept && (imem_rdata[OPC_MSB:OPC_LSB] == OP_HALT);
`ifdef FETCH_BYPASS_EN
    bypass      = accept && empty;
`else
    bypass      = 1'b0;
`endif
    head_instr  = bypass ? imem_rdata : rd_data[EW-1:PC_W];
    head_pc     = bypass ? req_addr_q : rd_data[PC_W-1:0];
    dec_valid   = !halted_q && (!empty || bypass);
    dec_instr   = dec_valid ? head_instr : NOP_WORD;
    dec_pc      = dec_valid ? head_pc : '0;
    dec_pc_inc  = dec_pc + PC_W'(2);
    consume     = dec_valid && dec_ready && !redir;
    pop         = consume && !bypass;
    push        = accept && !(bypass && dec_ready);
    wr_data     = {imem_rdata, req_addr_q};
    occ         = count + {{CW{1'b0}}, outstanding};
    // A HALT arriving this cycle must already suppress the next request.
    imem_req    = rst_n && (!outstanding || imem_valid) && (occ < DEPTH_V) && !full &&
                  !halt_pend_q && !halt_in && !halted_q && !redirect;
    imem_addr   = fetch_pc_q;
    halted      = halted_q;

    halted_d    = halted_q || (consume && (head_instr[OPC_MSB:OPC_LSB] == OP_HALT));
    halt_pend_d = redir ? 1'b0 : (halt_pend_q || halt_in);
    req_addr_d  = imem_req ? fetch_pc_q : req_addr_q;
    fetch_pc_d  = fetch_pc_q;
    if (redir)         fetch_pc_d = redirect_pc & ~PC_W'(1);
    else if (imem_req) fetch_pc_d = fetch_pc_q + PC_W'(2);

    state_d = state_q;
    case (state_q)
      FS_IDLE:          if (imem_req) state_d = FS_WAIT;
      FS_WAIT, FS_DROP: if (imem_valid) state_d = imem_req ? FS_WAIT : FS_IDLE;
      default:          state_d = FS_IDLE;
    endcase
    if (redir) state_d = (outstanding && !imem_valid) ? FS_DROP : FS_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= '0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= halted_d;
    end
  end
endmodule
